// File: rtl/and2_bist_if.sv
// Signal bundle between the and2 BIST controller (master) and the environment
// that owns start and the DUT response c (slave).
interface and2_bist_if #(
    parameter int WIDTH = 2
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             busy;
    logic             done;
    logic             pass;
    logic [7:0]       error_cnt;
    logic [7:0]       first_err_idx;

    modport master (
        input  start, c,
        output a, b, busy, done, pass, error_cnt, first_err_idx
    );

    modport slave (
        output start, c,
        input  a, b, busy, done, pass, error_cnt, first_err_idx
    );
endinterface

// File: rtl/and2_bist.sv
// Exhaustive-sweep BIST for an and2 block: drives {b,a} = vector index, checks
// c against a delayed a&b and reports mismatch count and first failing index.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | presenting vectors 0..NUM_VECTORS-1
// DRAIN | LATENCY cycles letting the last responses arrive
// DONE  | results held until next start
module and2_bist #(
    parameter int WIDTH       = 2,
    parameter int LATENCY     = 1,
    parameter int NUM_VECTORS = 16
) (
    input  logic           clk,
    input  logic           reset,
    and2_bist_if.master    bus
);
    localparam int AB_W  = 2 * WIDTH;
    localparam int IDX_W = 10;
    localparam int DRN_W = 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   vec_idx;
    logic [AB_W-1:0]    ab;
    logic [DRN_W-1:0]   drain_cnt;
    logic [WIDTH-1:0]   exp_pipe [LATENCY];
    logic [7:0]         idx_pipe [LATENCY];
    logic [LATENCY-1:0] vld_pipe;
    logic               busy_r;
    logic               done_r;
    logic               pass_r;
    logic [7:0]         err_r;
    logic [7:0]         fidx_r;

    logic               mismatch;
    logic [7:0]         err_next;

    always_comb begin
        mismatch = vld_pipe[LATENCY-1] && (bus.c != exp_pipe[LATENCY-1]);
        err_next = err_r;
        if (mismatch && err_r != 8'hFF) begin
            err_next = err_r + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            vec_idx   <= '0;
            ab        <= '0;
            drain_cnt <= '0;
            vld_pipe  <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                exp_pipe[i] <= '0;
                idx_pipe[i] <= '0;
            end
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            err_r     <= 8'd0;
            fidx_r    <= 8'd0;
        end else begin
            // Expected value and valid travel alongside the DUT's own latency.
            exp_pipe[0] <= ab[WIDTH-1:0] & ab[AB_W-1:WIDTH];
            idx_pipe[0] <= vec_idx[7:0];
            vld_pipe[0] <= (state == RUN);
            for (int i = 1; i < LATENCY; i++) begin
                exp_pipe[i] <= exp_pipe[i-1];
                idx_pipe[i] <= idx_pipe[i-1];
                vld_pipe[i] <= vld_pipe[i-1];
            end

            if (mismatch) begin
                err_r <= err_next;
                if (err_r == 8'd0) begin
                    fidx_r <= idx_pipe[LATENCY-1];
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state   <= RUN;
                        vec_idx <= '0;
                        ab      <= '0;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        pass_r  <= 1'b0;
                        err_r   <= 8'd0;
                        fidx_r  <= 8'hFF;
                    end
                end
                RUN: begin
                    if (vec_idx == IDX_W'(NUM_VECTORS - 1)) begin
                        state     <= DRAIN;
                        ab        <= '0;
                        drain_cnt <= DRN_W'(LATENCY - 1);
                    end else begin
                        vec_idx <= vec_idx + IDX_W'(1);
                        ab      <= ab + AB_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        pass_r <= (err_next == 8'd0);
                    end else begin
                        drain_cnt <= drain_cnt - DRN_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.a             = ab[WIDTH-1:0];
    assign bus.b             = ab[AB_W-1:WIDTH];
    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.pass          = pass_r;
    assign bus.error_cnt     = err_r;
    assign bus.first_err_idx = fidx_r;
endmodule

// File: tb/tb_and2_bist.sv
// Directed bench for and2_bist: four controller instances, each wired to its
// own behavioural and2 model (good, stuck, inverted, 3-cycle delayed).
module tb_and2_bist;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   c_mode = 0;

    and2_bist_if #(.WIDTH(2)) if_d ();
    and2_bist_if #(.WIDTH(2)) if_n ();
    and2_bist_if #(.WIDTH(2)) if_l3 ();
    and2_bist_if #(.WIDTH(2)) if_l1 ();

    and2_bist #(.WIDTH(2), .LATENCY(1), .NUM_VECTORS(16))  u_dflt (.clk(clk), .reset(rst_n), .bus(if_d));
    and2_bist #(.WIDTH(2), .LATENCY(1), .NUM_VECTORS(300)) u_n300 (.clk(clk), .reset(rst_n), .bus(if_n));
    and2_bist #(.WIDTH(2), .LATENCY(3), .NUM_VECTORS(16))  u_l3   (.clk(clk), .reset(rst_n), .bus(if_l3));
    and2_bist #(.WIDTH(2), .LATENCY(1), .NUM_VECTORS(16))  u_l1   (.clk(clk), .reset(rst_n), .bus(if_l1));

    logic       start_v [4];
    logic [1:0] a_v     [4];
    logic [1:0] b_v     [4];
    logic       busy_v  [4];
    logic       done_v  [4];
    logic       pass_v  [4];
    logic [7:0] err_v   [4];
    logic [7:0] fidx_v  [4];

    assign if_d.start  = start_v[0];
    assign if_n.start  = start_v[1];
    assign if_l3.start = start_v[2];
    assign if_l1.start = start_v[3];

    assign a_v[0] = if_d.a;   assign b_v[0] = if_d.b;   assign busy_v[0] = if_d.busy;
    assign a_v[1] = if_n.a;   assign b_v[1] = if_n.b;   assign busy_v[1] = if_n.busy;
    assign a_v[2] = if_l3.a;  assign b_v[2] = if_l3.b;  assign busy_v[2] = if_l3.busy;
    assign a_v[3] = if_l1.a;  assign b_v[3] = if_l1.b;  assign busy_v[3] = if_l1.busy;
    assign done_v[0] = if_d.done;  assign pass_v[0] = if_d.pass;
    assign done_v[1] = if_n.done;  assign pass_v[1] = if_n.pass;
    assign done_v[2] = if_l3.done; assign pass_v[2] = if_l3.pass;
    assign done_v[3] = if_l1.done; assign pass_v[3] = if_l1.pass;
    assign err_v[0] = if_d.error_cnt;  assign fidx_v[0] = if_d.first_err_idx;
    assign err_v[1] = if_n.error_cnt;  assign fidx_v[1] = if_n.first_err_idx;
    assign err_v[2] = if_l3.error_cnt; assign fidx_v[2] = if_l3.first_err_idx;
    assign err_v[3] = if_l1.error_cnt; assign fidx_v[3] = if_l1.first_err_idx;

    // Device models under test
    logic [1:0] c_d_reg, c_n_reg;
    logic [1:0] l3_d1, l3_d2, l3_d3, l1_d1, l1_d2, l1_d3;
    always_ff @(posedge clk) begin
        c_d_reg <= if_d.a & if_d.b;
        c_n_reg <= ~(if_n.a & if_n.b);
        l3_d1 <= if_l3.a & if_l3.b; l3_d2 <= l3_d1; l3_d3 <= l3_d2;
        l1_d1 <= if_l1.a & if_l1.b; l1_d2 <= l1_d1; l1_d3 <= l1_d2;
    end
    assign if_d.c  = (c_mode == 1) ? 2'b00 : c_d_reg;
    assign if_n.c  = c_n_reg;
    assign if_l3.c = l3_d3;
    assign if_l1.c = l1_d3;

    typedef struct {
        int         inst;
        logic [7:0] err;
        logic [7:0] fidx;
        logic       pass;
        int         busy_len;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_vec(input int inst, input int n, input int lat,
                           input logic [7:0] e_err, input logic [7:0] e_fidx,
                           input logic e_pass, input int pulse_at);
        exp_t e;
        exp_t g;
        int   cyc;
        int   blen;
        e.inst = inst; e.err = e_err; e.fidx = e_fidx; e.pass = e_pass; e.busy_len = n + lat;
        sb.push_back(e);
        start_v[inst] = 1'b1;
        @(negedge clk);
        start_v[inst] = 1'b0;
        cyc  = 0;
        blen = 0;
        while (done_v[inst] !== 1'b1 && cyc < n + lat + 20) begin
            if (busy_v[inst] === 1'b1) blen++;
            check($sformatf("i%0d_ab_c%0d", inst, cyc), {b_v[inst], a_v[inst]},
                  (cyc < n) ? (cyc % 16) : 0);
            start_v[inst] = (cyc == pulse_at);
            cyc++;
            @(negedge clk);
        end
        start_v[inst] = 1'b0;
        g = sb.pop_front();
        check($sformatf("i%0d_done", g.inst), done_v[inst], 1);
        check($sformatf("i%0d_busy_len", g.inst), blen, g.busy_len);
        check($sformatf("i%0d_busy_low", g.inst), busy_v[inst], 0);
        check($sformatf("i%0d_err", g.inst), err_v[inst], g.err);
        check($sformatf("i%0d_fidx", g.inst), fidx_v[inst], g.fidx);
        check($sformatf("i%0d_pass", g.inst), pass_v[inst], g.pass);
        repeat (3) @(negedge clk);
        check($sformatf("i%0d_done_held", g.inst), done_v[inst], 1);
        check($sformatf("i%0d_pass_held", g.inst), pass_v[inst], g.pass);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) start_v[i] = 1'b0;

        // Reset held 100 ns with start high
        start_v[0] = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_busy", busy_v[0], 0);
        check("rst_done", done_v[0], 0);
        check("rst_pass", pass_v[0], 0);
        check("rst_err", err_v[0], 0);
        check("rst_fidx", fidx_v[0], 0);
        check("rst_ab", {b_v[0], a_v[0]}, 0);
        start_v[0] = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", busy_v[0], 0);
        check("idle_done", done_v[0], 0);

        run_vec(0, 16, 1, 8'd0, 8'hFF, 1'b1, -1);

        c_mode = 1;
        run_vec(0, 16, 1, 8'd7, 8'd5, 1'b0, -1);
        c_mode = 0;

        run_vec(0, 16, 1, 8'd0, 8'hFF, 1'b1, 3);

        // Reset mid-run at vector 8
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        k = 0;
        while ({b_v[0], a_v[0]} !== 4'd8 && k < 40) begin
            k++;
            @(negedge clk);
        end
        check("midrst_reach_v8", {b_v[0], a_v[0]}, 8);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy_v[0], 0);
        check("midrst_done", done_v[0], 0);
        check("midrst_pass", pass_v[0], 0);
        check("midrst_err", err_v[0], 0);
        check("midrst_fidx", fidx_v[0], 0);
        check("midrst_ab", {b_v[0], a_v[0]}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("postrst_busy", busy_v[0], 0);
        check("postrst_done", done_v[0], 0);
        run_vec(0, 16, 1, 8'd0, 8'hFF, 1'b1, -1);

        run_vec(1, 300, 1, 8'd255, 8'd0, 1'b0, -1);
        run_vec(2, 16, 3, 8'd0, 8'hFF, 1'b1, -1);
        run_vec(3, 16, 1, 8'd8, 8'd5, 1'b0, -1);

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/and2_bist.md
AND2_BIST -- requirements
Module: and2_bist

Interface
REQ-001 Parameter WIDTH, default 2: bit width of the and2 operand and result buses.
REQ-002 Parameter LATENCY, default 1: DUT clock cycles from a/b applied to c valid; legal range 1..4.
REQ-003 Parameter NUM_VECTORS, default 16: number of vectors per run; legal range 1..1024.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  run request, sampled only in IDLE and DONE.
REQ-007 a  output  WIDTH  stimulus operand A to the DUT.
REQ-008 b  output  WIDTH  stimulus operand B to the DUT.
REQ-009 c  input  WIDTH  DUT response.
REQ-010 busy  output  1  high in RUN and DRAIN.
REQ-011 done  output  1  high in DONE; held until the next start or reset.
REQ-012 pass  output  1  done AND error_cnt==0.
REQ-013 error_cnt  output  8  number of mismatches in the current or last run; saturates at 255.
REQ-014 first_err_idx  output  8  low 8 bits of the first failing vector index; 8'hFF when no failure.

Function
REQ-015 The block SHALL contain a four-state FSM: IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE->RUN and DONE->RUN SHALL occur on the first clock edge with start=1; the same edge clears error_cnt to 0, sets first_err_idx to 8'hFF and sets vec_idx to 0.
REQ-017 start SHALL be ignored in RUN and DRAIN.
REQ-018 In RUN cycle k (k=0..NUM_VECTORS-1), {b,a} SHALL equal vec_idx[2*WIDTH-1:0] with vec_idx=k; the index wraps modulo 2^(2*WIDTH) on the bus.
REQ-019 RUN->DRAIN SHALL occur on the edge after vector NUM_VECTORS-1 is presented.
REQ-020 DRAIN SHALL last exactly LATENCY cycles and then go to DONE.
REQ-021 a and b SHALL be 0 in IDLE, DRAIN and DONE.
REQ-022 The expected value a&b and a valid flag SHALL be delayed through a LATENCY-deep shift pipeline; vector k is compared against c in cycle k+LATENCY after RUN entry.
REQ-023 Each compare with valid=1 and c != expected SHALL increment error_cnt, saturating at 255.
REQ-024 On the first mismatch of a run, first_err_idx SHALL capture the failing vector index [7:0]; later mismatches leave it unchanged.
REQ-025 No compare SHALL occur while valid=0, including the IDLE->RUN edge and cycles after DRAIN.
REQ-026 busy SHALL stay high for exactly NUM_VECTORS+LATENCY cycles per run.

Reset
REQ-027 reset low SHALL immediately force: state=IDLE, a=0, b=0, busy=0, done=0, pass=0, error_cnt=0, first_err_idx=0, pipeline valid bits=0.
REQ-028 Reset asserted mid-run SHALL abort the run, with no partial result retained.
REQ-029 After reset release, the block SHALL stay in IDLE until start is sampled high.

Verification
REQ-030 Reset check: hold reset low for 100 ns with start=1 -> all outputs 0 and state IDLE; after release the block stays IDLE until a start edge.
REQ-031 Good DUT (registered and2, defaults), 1-cycle start pulse -> busy high for 17 cycles; a/b sweep 0..15; then done=1, pass=1, error_cnt=0, first_err_idx=8'hFF.
REQ-032 c stuck at 2'b00 -> error_cnt=7, first_err_idx=5 (a=01, b=01), pass=0, done=1.
REQ-033 Start pulsed at vector 3 of a run -> run unaffected, busy still 17 cycles; reset pulsed at vector 8 -> immediate IDLE with zero outputs; a new start then completes a full run with pass=1.
REQ-034 NUM_VECTORS=300 with c=~(a&b) -> error_cnt saturates at 255, first_err_idx=0, pass=0.
REQ-035 LATENCY=3 with a DUT delayed 3 cycles -> pass=1, busy for 19 cycles; the same DUT tested with LATENCY=1 -> pass=0.
